alu_mdu: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Executes all RV base integer ALU ops plus the RV M-extension (mul/mulh/mulhsu/mulhu/div/divu/rem/remu) on XLEN-bit operands.
- Uses a valid/ready request port and a single-cycle result pulse, so the control unit can stall the pipeline while the iterative multiplier/divider runs.

---
 rtl/alu_mdu.sv | 151 +++++++++++++++
 tb/tb_alu_mdu.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// Multi-cycle RV integer ALU with iterative M-extension multiplier/divider.
// Valid/ready request side, single-cycle out_valid pulse on completion.
module alu_mdu #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opb;
    logic [2:0]        r_f3;
    logic              r_neg;
    logic [SHW:0]      r_cnt;
    logic [XLEN-1:0]   r_result;

    logic [SHW-1:0]    w_shamt;
    logic [XLEN-1:0]   w_base;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_neg;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_spec_res;
    logic              w_fast;
    logic [XLEN-1:0]   w_fast_res;
    logic [XLEN:0]     w_msum;
    logic              w_ge;
    logic [XLEN-1:0]   w_diff;
    logic [2*XLEN-1:0] w_step;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_dsel;
    logic [XLEN-1:0]   w_fix;

    assign w_shamt = b[SHW-1:0];

    always_comb begin
        w_base = '0;
        case (op[3:0])
            4'b0000: w_base = a + b;
            4'b1000: w_base = a - b;
            4'b0001: w_base = a << w_shamt;
            4'b0101: w_base = a >> w_shamt;
            4'b1101: w_base = $signed(a) >>> w_shamt;
            4'b0010: w_base = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            4'b0011: w_base = {{(XLEN-1){1'b0}}, a < b};
            4'b0100: w_base = a ^ b;
            4'b0110: w_base = a | b;
            4'b0111: w_base = a & b;
            default: w_base = '0;
        endcase
    end

    // Operand signedness by funct3: div/rem signed when op[0]=0.
    assign w_a_signed = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    assign w_b_signed = op[2] ? ~op[0] : ~op[1];
    assign w_a_neg    = w_a_signed & a[XLEN-1];
    assign w_b_neg    = w_b_signed & b[XLEN-1];
    assign w_a_mag    = w_a_neg ? -a : a;
    assign w_b_mag    = w_b_neg ? -b : b;
    assign w_neg      = (op[2] & op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

    assign w_div0     = (b == '0);
    assign w_ovf      = ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
    assign w_special  = op[2] & (w_div0 | w_ovf);
    assign w_spec_res = op[1] ? (w_div0 ? a : '0) : (w_div0 ? '1 : a);

    assign w_fast     = ~op[4] | ~ENABLE_M | w_special;
    assign w_fast_res = ~op[4] ? w_base : (ENABLE_M ? w_spec_res : '0);

    // Shift-add multiply: high half accumulates, low half shifts out the multiplier.
    assign w_msum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    // Restoring divide: high half is the partial remainder, low half the quotient.
    assign w_ge   = r_acc[2*XLEN-1:XLEN-1] >= {1'b0, r_opb};
    assign w_diff = r_acc[2*XLEN-2:XLEN-1] - r_opb;
    assign w_step = r_f3[2]
                  ? (w_ge ? {w_diff, r_acc[XLEN-2:0], 1'b1} : {r_acc[2*XLEN-2:0], 1'b0})
                  : {w_msum, r_acc[XLEN-1:1]};

    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_dsel = r_f3[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
    assign w_fix  = r_f3[2] ? (r_neg ? -w_dsel : w_dsel)
                  : ((r_f3 == 3'b000) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_opb    <= '0;
            r_f3     <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (w_fast) begin
                            r_result <= w_fast_res;
                            r_state  <= S_DONE;
                        end else begin
                            r_acc   <= {{XLEN{1'b0}}, w_a_mag};
                            r_opb   <= w_b_mag;
                            r_f3    <= op[2:0];
                            r_neg   <= w_neg;
                            r_cnt   <= '0;
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_cnt == (SHW+1)'(XLEN)) begin
                        r_result <= w_fix;
                        r_state  <= S_DONE;
                    end else begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_BUSY);
    assign result    = r_result;

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: directed plan vectors, random ops vs a
// plain-arithmetic model, mid-op reset, plus a 16-bit instance.
module tb_alu_mdu;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, out_valid, busy;
    logic [4:0]  op;
    logic [31:0] a, b, result;

    logic        rst16, iv16, ir16, ov16, busy16;
    logic [4:0]  op16;
    logic [15:0] a16, b16, res16;

    alu_mdu #(.XLEN(32), .ENABLE_M(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .result(result),
        .busy(busy)
    );

    alu_mdu #(.XLEN(16), .ENABLE_M(1'b1)) u_dut16 (
        .clk(clk), .rst(rst16), .in_valid(iv16), .in_ready(ir16),
        .op(op16), .a(a16), .b(b16), .out_valid(ov16), .result(res16),
        .busy(busy16)
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] exp_q[$];
    int          due_q[$];
    logic [31:0] m_e;
    int          m_d;

    function automatic logic [31:0] ref_model(input logic [4:0] o,
                                              input logic [31:0] x,
                                              input logic [31:0] y);
        logic signed [63:0] sx, sy, ps;
        logic        [63:0] ux, uy, pu;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'b0, x};
        uy = {32'b0, y};
        if (!o[4]) begin
            case (o[3:0])
                4'b0000: return x + y;
                4'b1000: return x - y;
                4'b0001: return x << y[4:0];
                4'b0101: return x >> y[4:0];
                4'b1101: return 32'($signed(x) >>> y[4:0]);
                4'b0010: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                4'b0011: return (x < y) ? 32'd1 : 32'd0;
                4'b0100: return x ^ y;
                4'b0110: return x | y;
                4'b0111: return x & y;
                default: return 32'd0;
            endcase
        end
        case (o[2:0])
            3'b000: begin ps = sx * sy; return ps[31:0]; end
            3'b001: begin ps = sx * sy; return ps[63:32]; end
            3'b010: begin ps = sx * $signed(uy); return ps[63:32]; end
            3'b011: begin pu = ux * uy; return pu[63:32]; end
            3'b100: begin
                if (y == 0) return 32'hFFFFFFFF;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return x;
                ps = sx / sy;
                return ps[31:0];
            end
            3'b101: return (y == 0) ? 32'hFFFFFFFF : x / y;
            3'b110: begin
                if (y == 0) return x;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'd0;
                ps = sx % sy;
                return ps[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int lat_of(input logic [4:0] o, input logic [31:0] x,
                                  input logic [31:0] y);
        if (!o[4]) return 0;
        if (o[2] && (y == 0)) return 0;
        if (o[2] && !o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF) return 0;
        return 33;
    endfunction

    // Scoreboard monitor: every out_valid pulse pops one expectation.
    always @(negedge clk) begin
        if (out_valid) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_valid at cycle %0d result=%h required=no pulse",
                         cyc, result);
            end else begin
                m_e = exp_q.pop_front();
                m_d = due_q.pop_front();
                if (result !== m_e || cyc != m_d || in_ready !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL result/latency: got %h at cycle %0d (rdy=%b busy=%b), required %h at cycle %0d (rdy=0 busy=0)",
                             result, cyc, in_ready, busy, m_e, m_d);
                end
            end
        end
    end

    task automatic issue(input logic [4:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] e);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            in_valid = 1'($urandom_range(0, 1));
            op = 5'($urandom);
            a  = $urandom;
            b  = $urandom;
            w++;
            @(negedge clk);
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL ready_timeout: in_ready=%b required=1", in_ready);
            in_valid = 1'b0;
            return;
        end
        in_valid = 1'b1;
        op = o;
        a  = x;
        b  = y;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        due_q.push_back(cyc + lat_of(o, x, y));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d pending, required 0", exp_q.size());
            exp_q.delete();
            due_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk16(input string nm, input logic [4:0] o,
                         input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] e, input int lat);
        int e0;
        int w = 0;
        @(negedge clk);
        iv16 = 1'b1;
        op16 = o;
        a16  = x;
        b16  = y;
        @(posedge clk);
        #1;
        e0   = cyc;
        iv16 = 1'b0;
        @(negedge clk);
        while (!ov16 && w < 60) begin
            iv16 = 1'($urandom_range(0, 1));
            op16 = 5'($urandom);
            a16  = 16'($urandom);
            b16  = 16'($urandom);
            w++;
            @(negedge clk);
        end
        iv16 = 1'b0;
        vectors++;
        if (!ov16 || res16 !== e || (cyc - e0) != lat) begin
            errors++;
            $display("FAIL %s: valid=%b result=%h after %0d, required %h after %0d",
                     nm, ov16, res16, cyc - e0, e, lat);
        end
    endtask

    typedef struct {
        logic [4:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] e;
    } vec_t;

    vec_t        dir[$];
    logic [4:0]  legal[$];
    logic [4:0]  ro;
    logic [31:0] rx, ry;
    logic [31:0] p32;
    logic signed [31:0] ps32;
    int          bad;

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0;
        rst16 = 1'b1; iv16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rst16 = 1'b0;

        vectors++;
        if (in_ready !== 1 || out_valid !== 0 || result !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL reset32: rdy=%b ov=%b res=%h busy=%b required 1 0 0 0",
                     in_ready, out_valid, result, busy);
        end
        vectors++;
        if (ir16 !== 1 || ov16 !== 0 || res16 !== 0 || busy16 !== 0) begin
            errors++;
            $display("FAIL reset16: rdy=%b ov=%b res=%h busy=%b required 1 0 0 0",
                     ir16, ov16, res16, busy16);
        end

        dir.push_back('{5'b00000, 32'd5,        32'hFFFFFFFD, 32'd2});
        dir.push_back('{5'b01101, 32'h80000000, 32'd36,       32'hF8000000});
        dir.push_back('{5'b00011, 32'd1,        32'hFFFFFFFF, 32'd1});
        dir.push_back('{5'b01001, 32'h1234,     32'h5678,     32'd0});
        dir.push_back('{5'b10001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF});
        dir.push_back('{5'b10000, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA});
        dir.push_back('{5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE});
        dir.push_back('{5'b10101, 32'd100,      32'd7,        32'd14});
        dir.push_back('{5'b10111, 32'd100,      32'd7,        32'd2});
        dir.push_back('{5'b10100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD});
        dir.push_back('{5'b10110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF});
        dir.push_back('{5'b10100, 32'd7,        32'd0,        32'hFFFFFFFF});
        dir.push_back('{5'b10110, 32'd7,        32'd0,        32'd7});
        dir.push_back('{5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000});
        dir.push_back('{5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'd0});
        foreach (dir[i]) issue(dir[i].o, dir[i].x, dir[i].y, dir[i].e);
        drain();

        legal = '{5'b00000, 5'b01000, 5'b00001, 5'b00101, 5'b01101, 5'b00010,
                  5'b00011, 5'b00100, 5'b00110, 5'b00111, 5'b10000, 5'b10001,
                  5'b10010, 5'b10011, 5'b10100, 5'b10101, 5'b10110, 5'b10111};
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) ro = 5'($urandom);
            else ro = legal[$urandom_range(0, legal.size() - 1)];
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0: ry = 32'd0;
                1: begin rx = 32'h80000000; ry = 32'hFFFFFFFF; end
                2: ry = 32'($urandom_range(0, 40));
                default: ;
            endcase
            issue(ro, rx, ry, ref_model(ro, rx, ry));
        end
        drain();

        // Abandon a 32-bit mul mid-iteration.
        in_valid = 1'b1; op = 5'b10000; a = 32'h1357; b = 32'h2468;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if (out_valid !== 0 || in_ready !== 1 || result !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL midreset32: ov=%b rdy=%b res=%h busy=%b required 0 1 0 0",
                     out_valid, in_ready, result, busy);
        end
        repeat (45) @(negedge clk);

        chk16("add16", 5'b00000, 16'h7FF0, 16'h0015, 16'h8005, 0);
        p32 = 32'h00001234 * 32'h00000056;
        chk16("mul16", 5'b10000, 16'h1234, 16'h0056, p32[15:0], 17);
        ps32 = -32'sd3 * 32'sd5;
        chk16("mulh16", 5'b10001, 16'hFFFD, 16'h0005, ps32[31:16], 17);
        chk16("divu16", 5'b10101, 16'd1000, 16'd7, 16'd142, 17);
        chk16("div0_16", 5'b10100, 16'd9, 16'd0, 16'hFFFF, 0);
        @(negedge clk);

        iv16 = 1'b1; op16 = 5'b10000; a16 = 16'h00AB; b16 = 16'h00CD;
        @(posedge clk);
        #1;
        iv16 = 1'b0;
        repeat (10) @(negedge clk);
        rst16 = 1'b1;
        @(posedge clk);
        #1;
        rst16 = 1'b0;
        vectors++;
        if (ov16 !== 0 || ir16 !== 1 || res16 !== 0 || busy16 !== 0) begin
            errors++;
            $display("FAIL midreset16: ov=%b rdy=%b res=%h busy=%b required 0 1 0 0",
                     ov16, ir16, res16, busy16);
        end
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (ov16) bad++;
        end
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midreset16_pulse: %0d out_valid pulses, required 0", bad);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
